// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin wormhole switch allocator for one router output.
// Grants are gated by, and consume, the credits of the downstream input buffer.
module noc_output_arbiter #(
    parameter int NUM_IN       = 5,
    parameter int CREDIT_DEPTH = 5,
    parameter int CNT_W        = 3,
    parameter int IDX_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req_i,
    input  logic [NUM_IN-1:0] head_i,
    input  logic [NUM_IN-1:0] tail_i,
    input  logic              credit_ret_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic              send_o,
    output logic              locked_o,
    output logic [IDX_W-1:0]  owner_o,
    output logic [CNT_W-1:0]  credit_cnt_o,
    output logic              credit_avail_o,
    output logic              err_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_next, owner_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              err_next;
    logic [NUM_IN-1:0] eligible;
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W:0]    cand_sum;
    logic [IDX_W-1:0]  cand;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_IN - 1)) return '0;
        return i + IDX_W'(1);
    endfunction

    assign eligible       = req_i & head_i;
    assign credit_avail_o = (credit_cnt_o != '0);
    assign send_o         = |grant_o;
    assign locked_o       = (state == LOCKED);

    // Round-robin search: first eligible input at or after rr_ptr, wrapping at NUM_IN.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_IN))
                cand_sum = cand_sum - (IDX_W+1)'(NUM_IN);
            cand = cand_sum[IDX_W-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        grant_o     = '0;
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner_o;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (credit_avail_o && found) begin
                        grant_o[winner] = 1'b1;
                        if (tail_i[winner]) begin
                            rr_ptr_next = wrap_inc(winner);
                        end else begin
                            state_next = LOCKED;
                            owner_next = winner;
                        end
                    end
                end
                LOCKED: begin
                    if (req_i[owner_o] && credit_avail_o) begin
                        grant_o[owner_o] = 1'b1;
                        if (tail_i[owner_o]) begin
                            state_next  = IDLE;
                            rr_ptr_next = wrap_inc(owner_o);
                            owner_next  = '0;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A return that would exceed the buffer depth saturates and flags a protocol error.
    always_comb begin
        cnt_next = credit_cnt_o;
        err_next = err_o;
        if (send_o && !credit_ret_i) begin
            cnt_next = credit_cnt_o - CNT_W'(1);
        end else if (!send_o && credit_ret_i) begin
            if (credit_cnt_o == CNT_W'(CREDIT_DEPTH))
                err_next = 1'b1;
            else
                cnt_next = credit_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner_o      <= '0;
            credit_cnt_o <= CNT_W'(CREDIT_DEPTH);
            err_o        <= 1'b0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_ptr_next;
            owner_o      <= owner_next;
            credit_cnt_o <= cnt_next;
            err_o        <= err_next;
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: scenario tasks drive the arbiter cycle by cycle; expected
// grants go through a scoreboard queue, registered outputs are compared inline.
module tb_noc_output_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req = '0, head = '0, tail = '0;
    logic       credit_ret = 1'b0;
    logic [4:0] grant;
    logic       send, locked, credit_avail, err;
    logic [2:0] owner, credit_cnt;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic [4:0] r, h, t;
        logic       cr;
        logic [4:0] g;
        logic [2:0] cnt;
        logic       lk;
        logic [2:0] own;
    } row_t;

    noc_output_arbiter #(
        .NUM_IN(5), .CREDIT_DEPTH(5), .CNT_W(3), .IDX_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req),
        .head_i(head),
        .tail_i(tail),
        .credit_ret_i(credit_ret),
        .grant_o(grant),
        .send_o(send),
        .locked_o(locked),
        .owner_o(owner),
        .credit_cnt_o(credit_cnt),
        .credit_avail_o(credit_avail),
        .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic rst, input logic [4:0] r, h, t, input logic cr,
                                input logic [4:0] g, input logic [2:0] cnt, input logic lk,
                                input logic [2:0] own);
        row_t x;
        x.rst = rst; x.r = r; x.h = h; x.t = t; x.cr = cr;
        x.g = g; x.cnt = cnt; x.lk = lk; x.own = own;
        return x;
    endfunction

    // Drive one cycle's inputs just after the rising edge, then wait to mid-cycle.
    task automatic tick(input logic rst, input logic [4:0] r, h, t, input logic cr);
        @(posedge clk);
        #1;
        reset = rst; req = r; head = h; tail = t; credit_ret = cr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] e;
        exp_q.push_back(5'b00000);
        tick(1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1);
        e = exp_q.pop_front();
        checks++; if (grant !== e) begin errors++; $display("[TB] FAIL reset_grant got=%b exp=%b", grant, e); end
        checks++; if (send !== 1'b0) begin errors++; $display("[TB] FAIL reset_send got=%b exp=0", send); end
        checks++; if (credit_cnt !== 3'd5) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=5", credit_cnt); end
        checks++; if (credit_avail !== 1'b1) begin errors++; $display("[TB] FAIL reset_avail got=%b exp=1", credit_avail); end
        checks++; if (locked !== 1'b0 || owner !== 3'd0) begin errors++; $display("[TB] FAIL reset_lock got=%b/%0d exp=0/0", locked, owner); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_round_robin();
        logic [4:0] seq [6];
        logic [4:0] e;
        seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00100;
        seq[3] = 5'b01000; seq[4] = 5'b10000; seq[5] = 5'b00001;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(seq[i]);
            tick(1'b0, 5'b11111, 5'b11111, 5'b11111, 1'b1);
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", i, grant, e); end
            checks++; if (credit_cnt !== 3'd5) begin errors++; $display("[TB] FAIL rr_cnt[%0d] got=%0d exp=5", i, credit_cnt); end
        end
        tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        checks++; if (credit_cnt !== 3'd5 || err !== 1'b0) begin errors++; $display("[TB] FAIL rr_end got cnt=%0d err=%b exp cnt=5 err=0", credit_cnt, err); end
    endtask

    task automatic test_wormhole();
        row_t rows[$];
        logic [4:0] e;
        rows.push_back(mk(0, 5'b00101, 5'b00101, 5'b00000, 1, 5'b00100, 5, 0, 0));
        rows.push_back(mk(0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 5, 1, 2));
        rows.push_back(mk(0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 5, 1, 2));
        rows.push_back(mk(0, 5'b00101, 5'b00001, 5'b00100, 1, 5'b00100, 5, 1, 2));
        rows.push_back(mk(0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 5, 0, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].g);
            tick(rows[i].rst, rows[i].r, rows[i].h, rows[i].t, rows[i].cr);
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("[TB] FAIL worm_grant[%0d] got=%b exp=%b", i, grant, e); end
            checks++; if (locked !== rows[i].lk || owner !== rows[i].own) begin errors++; $display("[TB] FAIL worm_lock[%0d] got=%b/%0d exp=%b/%0d", i, locked, owner, rows[i].lk, rows[i].own); end
        end
    endtask

    task automatic test_credit_exhaust();
        row_t rows[$];
        logic [4:0] e;
        tick(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        rows.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 5, 0, 0));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 4, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 3, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 2, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 1, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 1, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 1, 5'b00000, 0, 1, 1));
        rows.push_back(mk(0, 5'b00010, 5'b00000, 5'b00010, 0, 5'b00010, 1, 1, 1));
        rows.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].g);
            tick(rows[i].rst, rows[i].r, rows[i].h, rows[i].t, rows[i].cr);
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("[TB] FAIL cred_grant[%0d] got=%b exp=%b", i, grant, e); end
            checks++; if (send !== (|e)) begin errors++; $display("[TB] FAIL cred_send[%0d] got=%b exp=%b", i, send, |e); end
            checks++; if (credit_cnt !== rows[i].cnt) begin errors++; $display("[TB] FAIL cred_cnt[%0d] got=%0d exp=%0d", i, credit_cnt, rows[i].cnt); end
            checks++; if (credit_avail !== (rows[i].cnt != 3'd0)) begin errors++; $display("[TB] FAIL cred_avail[%0d] got=%b exp=%b", i, credit_avail, rows[i].cnt != 3'd0); end
            checks++; if (locked !== rows[i].lk || owner !== rows[i].own) begin errors++; $display("[TB] FAIL cred_lock[%0d] got=%b/%0d exp=%b/%0d", i, locked, owner, rows[i].lk, rows[i].own); end
        end
    endtask

    task automatic test_overflow();
        logic [4:0] e;
        for (int i = 0; i < 5; i++) tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        checks++; if (credit_cnt !== 3'd5 || err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pre got cnt=%0d err=%b exp cnt=5 err=0", credit_cnt, err); end
        exp_q.push_back(5'b00000);
        tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        e = exp_q.pop_front();
        checks++; if (grant !== e) begin errors++; $display("[TB] FAIL ovf_grant got=%b exp=%b", grant, e); end
        tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        checks++; if (credit_cnt !== 3'd5) begin errors++; $display("[TB] FAIL ovf_cnt got=%0d exp=5", credit_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err got=%b exp=1", err); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky[%0d] got=%b exp=1", i, err); end
        end
    endtask

    task automatic test_reset_mid_packet();
        row_t rows[$];
        logic [4:0] e;
        rows.push_back(mk(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 5, 0, 0));
        rows.push_back(mk(0, 5'b01000, 5'b01000, 5'b00000, 0, 5'b01000, 4, 0, 0));
        rows.push_back(mk(0, 5'b01000, 5'b00000, 5'b00000, 0, 5'b01000, 3, 1, 3));
        rows.push_back(mk(1, 5'b11111, 5'b11111, 5'b11111, 0, 5'b00000, 2, 1, 3));
        rows.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 0, 5'b00001, 5, 0, 0));
        rows.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 0, 5'b00010, 4, 0, 0));
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].g);
            tick(rows[i].rst, rows[i].r, rows[i].h, rows[i].t, rows[i].cr);
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("[TB] FAIL mid_grant[%0d] got=%b exp=%b", i, grant, e); end
            checks++; if (credit_cnt !== rows[i].cnt) begin errors++; $display("[TB] FAIL mid_cnt[%0d] got=%0d exp=%0d", i, credit_cnt, rows[i].cnt); end
            checks++; if (locked !== rows[i].lk || owner !== rows[i].own) begin errors++; $display("[TB] FAIL mid_lock[%0d] got=%b/%0d exp=%b/%0d", i, locked, owner, rows[i].lk, rows[i].own); end
            checks++; if (err !== (i < 4)) begin errors++; $display("[TB] FAIL mid_err[%0d] got=%b exp=%b", i, err, i < 4); end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_overflow();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
